// File: rtl/line_fill_buffer.sv
// Critical-word-first line fill buffer: fetches a 16-word line and stores the beats starting at the critical word, wrapping round.
// Optional beat-gap timeout abort is built only when LFB_TIMEOUT_EN is defined.
module line_fill_buffer
`ifdef LFB_TIMEOUT_EN
   #(parameter int unsigned TIMEOUT = 64)
`endif
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         fill_req,
   input  logic [15:0]  fill_addr,
   output logic         pmem_read,
   output logic [15:0]  pmem_address,
   input  logic         pmem_rvalid,
   input  logic [15:0]  pmem_rdata,
   output logic [255:0] line_words,
   output logic [3:0]   word_sel,
   output logic         crit_valid,
   output logic         line_valid,
   output logic         busy,
   output logic         fill_done,
   output logic         fill_err,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [10:0]    line_q, line_d;
   logic [3:0]     sel_q, sel_d;
   logic [3:0]     beat_cnt_q, beat_cnt_d;
   logic           crit_q, crit_d;
   logic           lvalid_q, lvalid_d;
   logic [255:0]   words_q, words_d;

   logic           accept;
   logic           beat;
   logic           last_beat;
   logic           timeout;
   logic [3:0]     widx;
   logic           unused_addr_bit;

   // Handshake: fill_req is taken only in IDLE; pmem_rvalid has no ready,
   // every valid beat seen in BURST is captured on that same edge.
   assign accept          = (state_q == S_IDLE) && fill_req;
   assign beat            = (state_q == S_BURST) && pmem_rvalid;
   assign last_beat       = beat && (beat_cnt_q == 4'hF);
   assign widx            = sel_q + beat_cnt_q;
   assign unused_addr_bit = fill_addr[0];

`ifdef LFB_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT + 1);
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             err_q, err_d;

   assign timeout = (state_q == S_BURST) && !pmem_rvalid && (gap_q == GAP_W'(TIMEOUT - 1));

   always_comb begin
      gap_d = gap_q;
      if (accept || beat)
         gap_d = '0;
      else if (state_q == S_BURST && !timeout)
         gap_d = gap_q + 1'b1;
      err_d = timeout;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_q <= '0;
         err_q <= 1'b0;
      end else begin
         gap_q <= gap_d;
         err_q <= err_d;
      end
   end

   assign fill_err = err_q;
`else
   assign timeout  = 1'b0;
   assign fill_err = 1'b0;
`endif

   // State register and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         line_q     <= '0;
         sel_q      <= '0;
         beat_cnt_q <= '0;
         crit_q     <= 1'b0;
         lvalid_q   <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         crit_q     <= crit_d;
         lvalid_q   <= lvalid_d;
         words_q    <= words_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (fill_req) state_d = S_BURST;
         S_BURST: begin
            if (last_beat)
               state_d = S_DONE;
            else if (timeout)
               state_d = S_IDLE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Stale words survive a new request; only captured beats overwrite them.
   always_comb begin
      line_d     = line_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      crit_d     = crit_q;
      lvalid_d   = lvalid_q;
      words_d    = words_q;
      if (accept) begin
         line_d     = fill_addr[15:5];
         sel_d      = fill_addr[4:1];
         beat_cnt_d = '0;
         crit_d     = 1'b0;
         lvalid_d   = 1'b0;
      end else if (beat) begin
         words_d[{widx, 4'h0} +: 16] = pmem_rdata;
         beat_cnt_d                  = beat_cnt_q + 1'b1;
         if (beat_cnt_q == 4'h0) crit_d   = 1'b1;
         if (last_beat)          lvalid_d = 1'b1;
      end
   end

   always_comb begin
      pmem_read = 1'b0;
      busy      = 1'b0;
      fill_done = 1'b0;
      unique case (state_q)
         S_BURST: begin
            pmem_read = 1'b1;
            busy      = 1'b1;
         end
         S_DONE:  fill_done = 1'b1;
         default: ;
      endcase
   end

   assign pmem_address = {line_q, 5'b0};
   assign line_words   = words_q;
   assign word_sel     = sel_q;
   assign crit_valid   = crit_q;
   assign line_valid   = lvalid_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer (default build, no timeout abort).
module tb_line_fill_buffer;

  logic         clk;
  logic         reset_n;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic         pmem_rvalid;
  logic [15:0]  pmem_rdata;
  logic [255:0] line_words;
  logic [3:0]   word_sel;
  logic         crit_valid;
  logic         line_valid;
  logic         busy;
  logic         fill_done;
  logic         fill_err;
  logic [1:0]   dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  line_fill_buffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rvalid  (pmem_rvalid),
    .pmem_rdata   (pmem_rdata),
    .line_words   (line_words),
    .word_sel     (word_sel),
    .crit_valid   (crit_valid),
    .line_valid   (line_valid),
    .busy         (busy),
    .fill_done    (fill_done),
    .fill_err     (fill_err),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_at(input int k);
    return line_words[k*16 +: 16];
  endfunction

  task automatic start_fill(input logic [15:0] addr);
    fill_req  = 1'b1;
    fill_addr = addr;
    step();
    fill_req  = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      pmem_rvalid = 1'b1;
      pmem_rdata  = base + 16'(b);
      step();
    end
    pmem_rvalid = 1'b0;
  endtask

  task automatic check_line(input string tag);
    for (int k = 0; k < 16; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_w%0d", tag, k), 256'(word_at(k)), 256'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},   256'(pmem_read),    256'(0));
    check({tag, "_addr"},   256'(pmem_address), 256'(0));
    check({tag, "_line"},   line_words,         256'(0));
    check({tag, "_sel"},    256'(word_sel),     256'(0));
    check({tag, "_crit"},   256'(crit_valid),   256'(0));
    check({tag, "_lvalid"}, 256'(line_valid),   256'(0));
    check({tag, "_busy"},   256'(busy),         256'(0));
    check({tag, "_done"},   256'(fill_done),    256'(0));
    check({tag, "_err"},    256'(fill_err),     256'(0));
    check({tag, "_state"},  256'(dbg_state_o),  256'(0));
  endtask

  initial begin
    int act_cycles;
    int done_pulses;
    int sent;

    // reset with random inputs
    reset_n     = 1'b0;
    fill_req    = 1'($urandom_range(0, 1));
    fill_addr   = 16'($urandom_range(0, 16'hFFFF));
    pmem_rvalid = 1'($urandom_range(0, 1));
    pmem_rdata  = 16'($urandom_range(0, 16'hFFFF));
    #1;
    check_reset_outputs("rst");
    repeat (2) step();
    fill_req    = 1'b0;
    pmem_rvalid = 1'b0;
    reset_n     = 1'b1;
    repeat (3) step();
    check_reset_outputs("idle");

    // critical word first: line 0x0D2, word 5
    start_fill(16'h1A4A);
    check("cwf_read", 256'(pmem_read),    256'(1));
    check("cwf_busy", 256'(busy),         256'(1));
    check("cwf_addr", 256'(pmem_address), 256'(16'h1A40));
    check("cwf_sel",  256'(word_sel),     256'(5));
    check("cwf_crit0", 256'(crit_valid),  256'(0));
    send_beats(16'h0100, 1);
    check("cwf_crit1",  256'(crit_valid), 256'(1));
    check("cwf_lv_mid", 256'(line_valid), 256'(0));
    check("cwf_w5",     256'(word_at(5)), 256'(16'h0100));
    send_beats(16'h0101, 14);
    check("cwf_read_b14", 256'(pmem_read), 256'(1));
    check("cwf_lv_b14",   256'(line_valid), 256'(0));
    send_beats(16'h010F, 1);
    check("cwf_lv",    256'(line_valid), 256'(1));
    check("cwf_done",  256'(fill_done),  256'(1));
    check("cwf_read_end", 256'(pmem_read), 256'(0));
    check("cwf_busy_end", 256'(busy),     256'(0));
    check("cwf_w15", 256'(word_at(15)), 256'(16'h010A));
    check("cwf_w0",  256'(word_at(0)),  256'(16'h010B));
    check("cwf_w4",  256'(word_at(4)),  256'(16'h010F));
    exp_q = '{16'h010B, 16'h010C, 16'h010D, 16'h010E, 16'h010F,
              16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104,
              16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109, 16'h010A};
    check_line("cwf");
    step();
    check("cwf_done_pulse", 256'(fill_done), 256'(0));
    check("cwf_sel_hold",   256'(word_sel),   256'(5));
    check("cwf_crit_hold",  256'(crit_valid), 256'(1));
    check("cwf_lv_hold",    256'(line_valid), 256'(1));

    // a beat in IDLE must not write
    pmem_rvalid = 1'b1;
    pmem_rdata  = 16'hFFFF;
    step();
    pmem_rvalid = 1'b0;
    check("idle_beat_w5", 256'(word_at(5)), 256'(16'h0100));
    check("idle_beat_w6", 256'(word_at(6)), 256'(16'h0101));

    // gapped burst from word 0, beats on every second edge
    start_fill(16'h2000);
    act_cycles  = 1;
    done_pulses = 0;
    sent        = 0;
    check("gap_crit_clr", 256'(crit_valid), 256'(0));
    check("gap_lv_clr",   256'(line_valid), 256'(0));
    check("gap_stale_w0", 256'(word_at(0)), 256'(16'h010B));
    for (int j = 1; j <= 40; j++) begin
      pmem_rvalid = (sent < 16) && (j % 2 == 0);
      pmem_rdata  = 16'hB000 + 16'(sent);
      step();
      if (pmem_rvalid) sent++;
      if (busy || fill_done) act_cycles++;
      if (fill_done) done_pulses++;
    end
    pmem_rvalid = 1'b0;
    // accept edge through DONE: 32 busy cycles plus the DONE cycle
    check("gap_cycles", 256'(act_cycles),  256'(33));
    check("gap_done1",  256'(done_pulses), 256'(1));
    check("gap_lv",     256'(line_valid),  256'(1));
    exp_q = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 16'hB005,
              16'hB006, 16'hB007, 16'hB008, 16'hB009, 16'hB00A, 16'hB00B,
              16'hB00C, 16'hB00D, 16'hB00E, 16'hB00F};
    check_line("gap");

    // requests while busy and in DONE are dropped
    start_fill(16'h3006);
    send_beats(16'hD000, 4);
    start_fill(16'hFFFE);
    check("ign_addr_busy", 256'(pmem_address), 256'(16'h3000));
    check("ign_sel_busy",  256'(word_sel),     256'(3));
    send_beats(16'hD004, 12);
    check("ign_done", 256'(fill_done), 256'(1));
    start_fill(16'h5554);
    check("ign_busy_after", 256'(busy),         256'(0));
    check("ign_addr_after", 256'(pmem_address), 256'(16'h3000));
    check("ign_sel_after",  256'(word_sel),     256'(3));
    step();
    check("ign_no_fill", 256'(busy), 256'(0));
    check("ign_w3",  256'(word_at(3)), 256'(16'hD000));
    check("ign_w2",  256'(word_at(2)), 256'(16'hD00F));

    // reset mid-burst then a fresh fill at word 15
    start_fill(16'h4010);
    send_beats(16'hE000, 7);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #2;
    reset_n = 1'b1;
    step();
    start_fill(16'h7FFE);
    check("re_addr", 256'(pmem_address), 256'(16'h7FE0));
    check("re_sel",  256'(word_sel),     256'(15));
    send_beats(16'hC000, 16);
    check("re_done", 256'(fill_done),   256'(1));
    check("re_lv",   256'(line_valid),  256'(1));
    check("re_crit", 256'(crit_valid),  256'(1));
    check("re_state", 256'(dbg_state_o), 256'(2));
    check("re_w15",  256'(word_at(15)), 256'(16'hC000));
    check("re_w0",   256'(word_at(0)),  256'(16'hC001));
    check("re_w14",  256'(word_at(14)), 256'(16'hC00F));
    check("re_err",  256'(fill_err),    256'(0));
    step();
    check("re_idle", 256'(dbg_state_o), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
